ofs_fim_pcie_ss_sb_tlp_arb: RTL and testbench

Packet-atomic round-robin arbiter that merges NUM_SRC PCIe SS AXI-S TLP streams onto one stream. All streams carry side-band headers in the high bits of tuser_vendor, one packet per cycle, SOP at tdata[0]. The output feeds the side-band-to-in-band header converter ahead of the PCIe SS TX port. Once a source is granted, it keeps the output until its tlast beat is accepted, so packets are never interleaved.

---
 rtl/ofs_fim_pcie_ss_sb_tlp_arb_if.sv | 40 ++++
 rtl/ofs_fim_pcie_ss_sb_tlp_arb.sv | 116 +++++++++++
 tb/tb_ofs_fim_pcie_ss_sb_tlp_arb.sv | 277 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/ofs_fim_pcie_ss_sb_tlp_arb_if.sv
// Stream bundle for the side-band TLP arbiter: NUM_SRC input AXI-S streams, one merged
// output stream, and arbiter state/pointer debug taps.
interface ofs_fim_pcie_ss_sb_tlp_arb_if #(
  parameter int NUM_SRC     = 4,
  parameter int TDATA_WIDTH = 512,
  parameter int TUSER_WIDTH = 266
);
  localparam int SRC_W  = $clog2(NUM_SRC);
  localparam int KEEP_W = TDATA_WIDTH / 8;

  logic [NUM_SRC-1:0]             in_tvalid;
  logic [NUM_SRC-1:0]             in_tready;
  logic [NUM_SRC*TDATA_WIDTH-1:0] in_tdata;
  logic [NUM_SRC*KEEP_W-1:0]      in_tkeep;
  logic [NUM_SRC-1:0]             in_tlast;
  logic [NUM_SRC*TUSER_WIDTH-1:0] in_tuser_vendor;

  logic                   out_tvalid;
  logic                   out_tready;
  logic [TDATA_WIDTH-1:0] out_tdata;
  logic [KEEP_W-1:0]      out_tkeep;
  logic                   out_tlast;
  logic [TUSER_WIDTH-1:0] out_tuser_vendor;
  logic [SRC_W-1:0]       out_src;

  logic                   dbg_state;
  logic [SRC_W-1:0]       dbg_rr_ptr;

  modport master (
    output in_tvalid, in_tdata, in_tkeep, in_tlast, in_tuser_vendor, out_tready,
    input  in_tready, out_tvalid, out_tdata, out_tkeep, out_tlast, out_tuser_vendor,
    input  out_src, dbg_state, dbg_rr_ptr
  );

  modport slave (
    input  in_tvalid, in_tdata, in_tkeep, in_tlast, in_tuser_vendor, out_tready,
    output in_tready, out_tvalid, out_tdata, out_tkeep, out_tlast, out_tuser_vendor,
    output out_src, dbg_state, dbg_rr_ptr
  );
endinterface

// File: rtl/ofs_fim_pcie_ss_sb_tlp_arb.sv
// Packet-atomic round-robin arbiter merging NUM_SRC side-band-header TLP streams into one
// registered stream. Define OFS_FIM_PCIE_SS_ARB_PRIO0_EN to give source 0 strict priority.
module ofs_fim_pcie_ss_sb_tlp_arb #(
  parameter int NUM_SRC     = 4,
  parameter int TDATA_WIDTH = 512,
  parameter int TUSER_WIDTH = 266
) (
  input logic clk,
  input logic rst_n,
  ofs_fim_pcie_ss_sb_tlp_arb_if.slave bus
);
  localparam int SRC_W  = $clog2(NUM_SRC);
  localparam int KEEP_W = TDATA_WIDTH / 8;
`ifdef OFS_FIM_PCIE_SS_ARB_PRIO0_EN
  localparam bit PRIO0 = 1'b1;
`else
  localparam bit PRIO0 = 1'b0;
`endif

  typedef enum logic { IDLE = 1'b0, LOCKED = 1'b1 } state_t;

  state_t             state;
  logic [SRC_W-1:0]   rr_ptr, grant, pick, sel, src_q;
  logic               pick_vld, can_load, take, valid_q, last_q;
  logic [NUM_SRC-1:0] ready;
  logic [TDATA_WIDTH-1:0] data_q;
  logic [KEEP_W-1:0]      keep_q;
  logic [TUSER_WIDTH-1:0] user_q;

  // Handshake: a beat moves when tvalid and tready are both high at a rising clk edge.
  // The output stage loads whenever it is empty or being drained in the same cycle.
  assign can_load = !valid_q || bus.out_tready;

  function automatic logic [SRC_W-1:0] next_ptr(input logic [SRC_W-1:0] g);
    logic [SRC_W-1:0] n;
    if (int'(g) == NUM_SRC - 1) n = '0;
    else                        n = g + 1'b1;
    if (PRIO0 && n == '0) n = SRC_W'(1);
    return n;
  endfunction

  always_comb begin
    logic [SRC_W-1:0] idx;
    idx      = '0;
    pick     = '0;
    pick_vld = 1'b0;
    for (int k = 0; k < NUM_SRC; k++) begin
      idx = SRC_W'((int'(rr_ptr) + k) % NUM_SRC);
      if (!pick_vld && bus.in_tvalid[idx] && !(PRIO0 && idx == '0)) begin
        pick_vld = 1'b1;
        pick     = idx;
      end
    end
    if (PRIO0 && bus.in_tvalid[0]) begin
      pick_vld = 1'b1;
      pick     = '0;
    end
  end

  // In LOCKED the owner's ready follows the stage alone, so a stalled owner keeps the grant.
  always_comb begin
    ready = '0;
    sel   = grant;
    if (state == IDLE) begin
      sel = pick;
      if (can_load && pick_vld) ready[pick] = 1'b1;
    end else begin
      ready[grant] = can_load;
    end
    if (!rst_n) ready = '0;
  end

  assign take = |(bus.in_tvalid & ready);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      rr_ptr  <= '0;
      grant   <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      src_q   <= '0;
    end else if (take) begin
      valid_q <= 1'b1;
      last_q  <= bus.in_tlast[sel];
      src_q   <= sel;
      grant   <= sel;
      if (bus.in_tlast[sel]) begin
        state  <= IDLE;
        rr_ptr <= next_ptr(sel);
      end else begin
        state  <= LOCKED;
      end
    end else if (bus.out_tready) begin
      valid_q <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (take) begin
      data_q <= bus.in_tdata[int'(sel)*TDATA_WIDTH +: TDATA_WIDTH];
      keep_q <= bus.in_tkeep[int'(sel)*KEEP_W +: KEEP_W];
      user_q <= bus.in_tuser_vendor[int'(sel)*TUSER_WIDTH +: TUSER_WIDTH];
    end
  end

  assign bus.in_tready        = ready;
  assign bus.out_tvalid       = valid_q;
  assign bus.out_tlast        = last_q;
  assign bus.out_src          = src_q;
  assign bus.out_tdata        = data_q;
  assign bus.out_tkeep        = keep_q;
  assign bus.out_tuser_vendor = user_q;
  assign bus.dbg_state        = (state == LOCKED);
  assign bus.dbg_rr_ptr       = rr_ptr;
endmodule

// File: tb/tb_ofs_fim_pcie_ss_sb_tlp_arb.sv
// Bench for ofs_fim_pcie_ss_sb_tlp_arb: arbitration table, packet sequences, scoreboard
// of expected output beats.
module tb_ofs_fim_pcie_ss_sb_tlp_arb;
  localparam int NS = 4;
  localparam int DW = 512;
  localparam int UW = 266;
  localparam int KW = DW / 8;
  localparam int SW = $clog2(NS);

  typedef struct packed {
    logic [DW-1:0] data;
    logic [KW-1:0] keep;
    logic [UW-1:0] user;
    logic          last;
  } beat_t;

  typedef struct packed {
    logic [SW-1:0] src;
    beat_t         b;
  } exp_t;

  localparam int EXP_W = $bits(exp_t);

  typedef struct {
    logic [NS-1:0] mask;
    int            win;
  } arb_vec_t;

  logic clk = 1'b0;
  logic rst_n;
  logic rst_drv;
  logic tready_drv;
  logic [NS-1:0] src_en;
  logic [NS-1:0] last_ready;
  logic [EXP_W-1:0] exp_q[$];
  beat_t src_q[NS][$];
  exp_t  hold;
  logic  hold_vld;
  int    n_cmp = 0;
  int    n_fail = 0;

  ofs_fim_pcie_ss_sb_tlp_arb_if #(.NUM_SRC(NS), .TDATA_WIDTH(DW), .TUSER_WIDTH(UW)) bus ();

  ofs_fim_pcie_ss_sb_tlp_arb #(.NUM_SRC(NS), .TDATA_WIDTH(DW), .TUSER_WIDTH(UW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [511:0] act, input logic [511:0] want);
    n_cmp++;
    if (act !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h", name, act, want);
    end
  endtask

  task automatic cmp_beat(input string pfx, input exp_t act, input exp_t want);
    chk({pfx, "_src"},  512'(act.src),    512'(want.src));
    chk({pfx, "_last"}, 512'(act.b.last), 512'(want.b.last));
    chk({pfx, "_data"}, act.b.data,       want.b.data);
    chk({pfx, "_keep"}, 512'(act.b.keep), 512'(want.b.keep));
    chk({pfx, "_user"}, 512'(act.b.user), 512'(want.b.user));
  endtask

  function automatic beat_t mk_beat(input logic last);
    beat_t b;
    for (int w = 0; w < DW / 32; w++) b.data[w*32 +: 32] = $urandom;
    for (int w = 0; w < KW / 32; w++) b.keep[w*32 +: 32] = $urandom;
    for (int w = 0; w < UW; w++) b.user[w] = 1'($urandom_range(1, 0));
    b.last = last;
    return b;
  endfunction

  // driver: queue a packet on one source; optionally record it as expected output
  task automatic send(input int src, input int nbeats, input bit want);
    beat_t b;
    exp_t  e;
    for (int k = 0; k < nbeats; k++) begin
      b = mk_beat(k == nbeats - 1);
      src_q[src].push_back(b);
      if (want) begin
        e.src = SW'(src);
        e.b   = b;
        exp_q.push_back(e);
      end
    end
  endtask

  // one cycle: drive at negedge, sample 1 time unit later, then wait for the next negedge
  task automatic tick();
    logic [NS-1:0] v;
    exp_t cur;
    exp_t e;
    beat_t b;
    v = '0;
    for (int i = 0; i < NS; i++) begin
      b = '0;
      if (src_en[i] && src_q[i].size() > 0) begin
        v[i] = 1'b1;
        b = src_q[i][0];
      end
      bus.in_tdata[i*DW +: DW]        = b.data;
      bus.in_tkeep[i*KW +: KW]        = b.keep;
      bus.in_tuser_vendor[i*UW +: UW] = b.user;
      bus.in_tlast[i]                 = b.last;
    end
    bus.in_tvalid  = v;
    bus.out_tready = tready_drv;
    rst_n          = rst_drv;
    #1;
    last_ready = bus.in_tready;
    cur.src    = bus.out_src;
    cur.b.data = bus.out_tdata;
    cur.b.keep = bus.out_tkeep;
    cur.b.user = bus.out_tuser_vendor;
    cur.b.last = bus.out_tlast;
    if (!rst_drv) begin
      hold_vld = 1'b0;
      chk("ready_in_reset", 512'(bus.in_tready), 512'(0));
    end else begin
      if (hold_vld) begin
        chk("hold_valid", 512'(bus.out_tvalid), 512'(1));
        cmp_beat("hold", cur, hold);
      end
      chk("ready_onehot", 512'($countones(bus.in_tready) <= 1), 512'(1));
      if (bus.out_tvalid && !bus.out_tready)
        chk("ready_while_held", 512'(bus.in_tready), 512'(0));
      if (bus.out_tvalid && bus.out_tready) begin
        if (exp_q.size() == 0) chk("unexpected_beat", 512'(1), 512'(0));
        else begin
          e = exp_q.pop_front();
          cmp_beat("out", cur, e);
        end
      end
      hold_vld = bus.out_tvalid && !bus.out_tready;
      hold     = cur;
    end
    for (int i = 0; i < NS; i++)
      if (v[i] && bus.in_tready[i]) void'(src_q[i].pop_front());
    @(negedge clk);
  endtask

  task automatic run(input int budget, output int cycles);
    cycles = 0;
    while (exp_q.size() != 0 && cycles < budget) begin
      tick();
      cycles++;
    end
    chk("drain_timeout", 512'(exp_q.size()), 512'(0));
  endtask

  initial begin
    arb_vec_t tbl[10];
    logic [NS-1:0] masks[10];
    int win_tbl[10];
    int c;
    int pre;
    masks = '{4'b1111, 4'b1111, 4'b0001, 4'b1001, 4'b0110,
              4'b0011, 4'b1100, 4'b0100, 4'b1010, 4'b1010};
`ifdef OFS_FIM_PCIE_SS_ARB_PRIO0_EN
    win_tbl = '{0, 0, 0, 0, 1, 0, 2, 2, 3, 1};
`else
    win_tbl = '{0, 1, 0, 3, 1, 0, 2, 2, 3, 1};
`endif
    for (int i = 0; i < 10; i++) begin
      tbl[i].mask = masks[i];
      tbl[i].win  = win_tbl[i];
    end

    bus.in_tvalid = '0; bus.in_tdata = '0; bus.in_tkeep = '0;
    bus.in_tlast = '0; bus.in_tuser_vendor = '0; bus.out_tready = 1'b1;
    rst_drv = 1'b0; rst_n = 1'b0; tready_drv = 1'b1; src_en = '1; hold_vld = 1'b0;
    @(negedge clk);
    repeat (3) tick();
    rst_drv = 1'b1;
    tick();
    chk("rst_out_tvalid", 512'(bus.out_tvalid), 512'(0));
    chk("rst_out_tlast",  512'(bus.out_tlast),  512'(0));
    chk("rst_out_src",    512'(bus.out_src),    512'(0));
    chk("rst_in_tready",  512'(bus.in_tready),  512'(0));
    chk("rst_state",      512'(bus.dbg_state),  512'(0));
    chk("rst_rr_ptr",     512'(bus.dbg_rr_ptr), 512'(0));

    // arbitration table: single-beat packets, losers withdrawn after each cycle
    for (int v = 0; v < 10; v++) begin
      for (int i = 0; i < NS; i++)
        if (tbl[v].mask[i]) send(i, 1, i == tbl[v].win);
      tick();
      chk($sformatf("arb_ready_v%0d", v), 512'(last_ready), 512'(1) << tbl[v].win);
      for (int i = 0; i < NS; i++) src_q[i].delete();
    end
    run(5, c);
    chk("tbl_rr_ptr", 512'(bus.dbg_rr_ptr), 512'(2));

    // single 3-beat packet from src2
    send(2, 3, 1'b1);
    tick();
    chk("sop_latency", 512'(bus.out_tvalid), 512'(1));
    run(10, c);
    chk("single_pkt_cycles", 512'(c), 512'(3));
    chk("single_rr_ptr", 512'(bus.dbg_rr_ptr), 512'(3));

    // src0 4-beat packet, src1 requests from the next cycle
    send(0, 4, 1'b1);
    tick();
    send(1, 2, 1'b1);
    c = 0;
    while (exp_q.size() != 0 && c < 20) begin
      pre = src_q[0].size();
      tick();
      if (pre > 0) chk("no_interleave_ready1", 512'(last_ready[1]), 512'(0));
      c++;
    end
    chk("b2b_no_bubble", 512'(c), 512'(6));

    // backpressure during a 2-beat packet
    send(1, 2, 1'b1);
    tready_drv = 1'b1; tick();
    tready_drv = 1'b0; tick();
    chk("bp_ready_held_a", 512'(last_ready), 512'(0));
    tick();
    chk("bp_ready_held_b", 512'(last_ready), 512'(0));
    tready_drv = 1'b1;
    run(10, c);

    // reset on beat 2 of a 4-beat src3 packet
    send(3, 4, 1'b1);
    tick();
    tick();
    rst_drv = 1'b0;
    src_q[3].delete();
    exp_q.delete();
    tick();
    rst_drv = 1'b1;
    chk("midrst_out_tvalid", 512'(bus.out_tvalid), 512'(0));
    chk("midrst_in_tready",  512'(bus.in_tready),  512'(0));
    chk("midrst_state",      512'(bus.dbg_state),  512'(0));
    chk("midrst_rr_ptr",     512'(bus.dbg_rr_ptr), 512'(0));
    send(1, 1, 1'b1);
    send(3, 1, 1'b1);
    run(10, c);
    chk("post_rst_cycles", 512'(c), 512'(3));

    // all sources streaming single-beat packets
`ifdef OFS_FIM_PCIE_SS_ARB_PRIO0_EN
    for (int r = 0; r < 3; r++) send(0, 1, 1'b1);
    for (int r = 0; r < 3; r++)
      for (int i = 1; i < NS; i++) send(i, 1, 1'b1);
`else
    for (int r = 0; r < 3; r++)
      for (int i = 0; i < NS; i++) send(i, 1, 1'b1);
`endif
    run(40, c);
    chk("full_rate_cycles", 512'(c), 512'(13));

    // owner drops tvalid mid-packet while src0 waits
    send(1, 3, 1'b1);
    tick();
    src_en[1] = 1'b0;
    send(0, 1, 1'b1);
    tick();
    chk("stall_other_ready", 512'(last_ready[0]), 512'(0));
    tick();
    chk("stall_out_tvalid", 512'(bus.out_tvalid), 512'(0));
    chk("stall_state_locked", 512'(bus.dbg_state), 512'(1));
    src_en[1] = 1'b1;
    run(20, c);
    chk("stall_cycles", 512'(c), 512'(4));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
